// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                FSM state encoding, storage geometry, wait-counter sizing,
//                address index slice bounds and the byte-lane merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEPTH           = 2048;
  localparam int WAIT_CYCLES_MAX = 15;
  localparam int ADDR_IDX_HI     = 12;
  localparam int ADDR_IDX_LO     = 2;
  localparam int IDX_W           = ADDR_IDX_HI - ADDR_IDX_LO + 1;
  localparam int CNT_W           = $clog2(WAIT_CYCLES_MAX + 1);

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_if
//  Description : CPU-to-data-memory request/response bundle. The master side
//                issues requests; the slave side answers with a one-cycle
//                response strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata, err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word-organised storage with one asynchronous read port and
//                one synchronous byte-enabled write port. Contents are not
//                reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = dmem_pkg::DEPTH
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wbe,
  input  logic [31:0]      wdata
);

  logic [31:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // Byte-lane write: untouched lanes keep their previous contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= merge_lanes(mem[waddr], wdata, wbe);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder. Accepts one request in
//                IDLE, waits WAIT_CYCLES cycles, then issues a one-cycle
//                response. Stores commit on the edge that ends the response;
//                misaligned accesses respond with err and never write.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = dmem_pkg::DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk_in,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Captured request
  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  logic             r_misalign;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;

  // Registered response
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             w_rvalid_nxt;
  logic [31:0]      w_rdata_nxt;
  logic             w_err_nxt;

  logic             w_accept;
  logic             w_cur_we;
  logic             w_cur_misalign;
  logic [IDX_W-1:0] w_cur_idx;
  logic [31:0]      w_mem_rdata;
  logic             w_mem_we;
  logic             w_unused_addr_hi;

  assign w_accept = bus.req && (r_state == ST_IDLE);

  // In IDLE the request being accepted is still on the bus (only matters for a
  // zero-wait response); afterwards the captured copy is authoritative.
  assign w_cur_we       = (r_state == ST_IDLE) ? bus.we : r_we;
  assign w_cur_misalign = (r_state == ST_IDLE) ? (bus.addr[1:0] != 2'b00) : r_misalign;
  assign w_cur_idx      = (r_state == ST_IDLE) ? bus.addr[ADDR_IDX_HI:ADDR_IDX_LO] : r_idx;

  // The write is gated by reset so an access aborted in RESP never commits.
  assign w_mem_we = (r_state == ST_RESP) && r_we && !r_misalign && reset;

  // Upper address bits select nothing: addresses alias modulo the array size.
  assign w_unused_addr_hi = &{1'b0, bus.addr[31:ADDR_IDX_HI+1]};

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk_in),
    .raddr (w_cur_idx),
    .rdata (w_mem_rdata),
    .we    (w_mem_we),
    .waddr (r_idx),
    .wbe   (r_be),
    .wdata (r_wdata)
  );

  // Next-state, wait counter and next response values.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rvalid_nxt = 1'b0;
    w_rdata_nxt  = 32'h0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // No store can land between acceptance and RESP, so reading here yields
    // the word as it was when the request was accepted.
    if (w_state_nxt == ST_RESP) begin
      w_rvalid_nxt = 1'b1;
      w_err_nxt    = w_cur_misalign;
      if (!w_cur_we && !w_cur_misalign) w_rdata_nxt = w_mem_rdata;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture on acceptance; later bus changes are ignored.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_misalign <= 1'b0;
      r_wdata    <= 32'h0;
      r_be       <= 4'h0;
    end else if (w_accept) begin
      r_we       <= bus.we;
      r_idx      <= bus.addr[ADDR_IDX_HI:ADDR_IDX_LO];
      r_misalign <= (bus.addr[1:0] != 2'b00);
      r_wdata    <= bus.wdata;
      r_be       <= bus.be;
    end
  end

  // Response output registers, zero outside RESP.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rvalid_nxt;
      r_rdata  <= w_rdata_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.ready  = (r_state == ST_IDLE);
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench. Two responders share a clock:
//                bus_a with WAIT_CYCLES=2 and bus_b with WAIT_CYCLES=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk_in;
  logic        rst_a;
  logic        rst_b;
  logic        dut_sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;

  int total;
  int bad;

  dmem_if bus_a ();
  dmem_if bus_b ();

  assign bus_a.req   = req && (dut_sel == 1'b0);
  assign bus_a.we    = we;
  assign bus_a.addr  = addr;
  assign bus_a.wdata = wdata;
  assign bus_a.be    = be;
  assign bus_b.req   = req && (dut_sel == 1'b1);
  assign bus_b.we    = we;
  assign bus_b.addr  = addr;
  assign bus_b.wdata = wdata;
  assign bus_b.be    = be;

  dmem_responder #(
    .DEPTH       (2048),
    .WAIT_CYCLES (2)
  ) u_dut_a (
    .clk_in (clk_in),
    .reset  (rst_a),
    .bus    (bus_a)
  );

  dmem_responder #(
    .DEPTH       (2048),
    .WAIT_CYCLES (0)
  ) u_dut_b (
    .clk_in (clk_in),
    .reset  (rst_b),
    .bus    (bus_b)
  );

  always_comb begin
    if (dut_sel == 1'b0) begin
      m_ready  = bus_a.ready;
      m_rvalid = bus_a.rvalid;
      m_rdata  = bus_a.rdata;
      m_err    = bus_a.err;
    end else begin
      m_ready  = bus_b.ready;
      m_rvalid = bus_b.rvalid;
      m_rdata  = bus_b.rdata;
      m_err    = bus_b.err;
    end
  end

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Wait (bounded) for ready, present one request for one cycle, then scramble
  // the bus so that only the captured copy can produce the right answer.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    int guard;
    guard = 0;
    while (!m_ready && guard < 50) begin
      @(posedge clk_in); #1;
      guard++;
    end
    total++;
    if (m_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready_timeout: ready=%b required=1", m_ready);
    end
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk_in); #1;
    req = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; be = 4'hF;
  endtask

  // Returns in the RESP cycle; lat counts cycles after the acceptance cycle.
  task automatic wait_resp(output logic [31:0] rd, output logic e, output int lat);
    lat = 1;
    while (!m_rvalid && lat < 40) begin
      @(posedge clk_in); #1;
      lat++;
    end
    rd = m_rdata;
    e  = m_err;
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e,
                        output int lat);
    issue(w, a, d, b);
    wait_resp(rd, e, lat);
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    dut_sel = 1'b0;
    total++; if (m_ready !== 1'b1)     begin bad++; $display("FAIL reset_ready: got=%b exp=1", m_ready); end
    total++; if (m_rvalid !== 1'b0)    begin bad++; $display("FAIL reset_rvalid: got=%b exp=0", m_rvalid); end
    total++; if (m_rdata !== 32'h0)    begin bad++; $display("FAIL reset_rdata: got=%h exp=0", m_rdata); end
    total++; if (m_err !== 1'b0)       begin bad++; $display("FAIL reset_err: got=%b exp=0", m_err); end
    total++; if (bus_b.ready !== 1'b1) begin bad++; $display("FAIL reset_ready_b: got=%b exp=1", bus_b.ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    dut_sel = 1'b0;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    total++; if (lat != 3)        begin bad++; $display("FAIL store_latency: got=%0d exp=3", lat); end
    total++; if (rd !== 32'h0)    begin bad++; $display("FAIL store_rdata: got=%h exp=0", rd); end
    total++; if (e !== 1'b0)      begin bad++; $display("FAIL store_err: got=%b exp=0", e); end
    total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL resp_ready: got=%b exp=0", m_ready); end
    @(posedge clk_in); #1;
    total++; if (m_ready !== 1'b1)  begin bad++; $display("FAIL ready_after_resp: got=%b exp=1", m_ready); end
    total++; if (m_rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_one_cycle: got=%b exp=0", m_rvalid); end
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_0x10: got=%h exp=deadbeef", rd); end
    total++; if (e !== 1'b0)          begin bad++; $display("FAIL load_err: got=%b exp=0", e); end
    total++; if (lat != 3)            begin bad++; $display("FAIL load_latency: got=%0d exp=3", lat); end
    @(posedge clk_in); #1;
    total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL rdata_idle: got=%h exp=0", m_rdata); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic e; int lat;
    dut_sel = 1'b0;
    access(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat);
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL byte_enable_merge: got=%h exp=11bb33dd", rd); end
    access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
    total++; if (lat != 3 || e !== 1'b0) begin bad++; $display("FAIL be0_response: lat=%0d err=%b exp lat=3 err=0", lat, e); end
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be0_no_write: got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic e; int lat;
    dut_sel = 1'b0;
    access(1'b0, 32'h22, 32'h0, 4'h0, rd, e, lat);
    total++; if (e !== 1'b1)       begin bad++; $display("FAIL misaligned_load_err: got=%b exp=1", e); end
    total++; if (rd !== 32'h0)     begin bad++; $display("FAIL misaligned_load_rdata: got=%h exp=0", rd); end
    total++; if (lat != 3)         begin bad++; $display("FAIL misaligned_latency: got=%0d exp=3", lat); end
    access(1'b1, 32'h22, 32'hCAFEBABE, 4'hF, rd, e, lat);
    total++; if (e !== 1'b1)       begin bad++; $display("FAIL misaligned_store_err: got=%b exp=1", e); end
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h11BB33DD || e !== 1'b0) begin
      bad++; $display("FAIL misaligned_no_write: got=%h err=%b exp=11bb33dd err=0", rd, e);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic e; int lat;
    dut_sel = 1'b0;
    access(1'b1, 32'h2004, 32'h5, 4'hF, rd, e, lat);
    access(1'b0, 32'h4, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h5) begin bad++; $display("FAIL wrap_load: got=%h exp=5", rd); end
  endtask

  // req held high; addr flips to 0x20 whenever ready is low, so every response
  // must still carry the word at 0x10.
  task automatic test_back_to_back();
    int pulses; int last; int guard;
    dut_sel = 1'b0;
    pulses = 0; last = -1; guard = 0;
    while (!m_ready && guard < 20) begin @(posedge clk_in); #1; guard++; end
    for (int c = 0; c < 16; c++) begin
      if (m_rvalid) begin
        pulses++;
        total++; if (m_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_rdata: cycle=%0d got=%h exp=deadbeef", c, m_rdata); end
        if (last >= 0) begin
          total++; if (c - last != 4) begin bad++; $display("FAIL hold_spacing: got=%0d exp=4", c - last); end
        end
        last = c;
      end
      req = 1'b1; we = 1'b0; be = 4'h0;
      addr = m_ready ? 32'h10 : 32'h20;
      @(posedge clk_in); #1;
    end
    req = 1'b0;
    total++; if (pulses != 4) begin bad++; $display("FAIL hold_count: got=%0d exp=4", pulses); end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat; int seen;
    dut_sel = 1'b0;
    access(1'b1, 32'h30, 32'h01020304, 4'hF, rd, e, lat);
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    rst_a = 1'b0;
    @(posedge clk_in); #1;
    rst_a = 1'b1;
    total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL abort_wait_ready: got=%b exp=1", m_ready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_rvalid) seen++;
      @(posedge clk_in); #1;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_wait_rvalid: got=%0d pulses exp=0", seen); end
    access(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL abort_wait_mem: got=%h exp=01020304", rd); end
    access(1'b1, 32'h30, 32'hBAD0BAD0, 4'hF, rd, e, lat);
    rst_a = 1'b0;
    @(posedge clk_in); #1;
    rst_a = 1'b1;
    access(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL abort_resp_mem: got=%h exp=01020304", rd); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic e; int lat;
    dut_sel = 1'b1;
    access(1'b1, 32'h40, 32'h12345678, 4'hF, rd, e, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL zw_store_latency: got=%0d exp=1", lat); end
    access(1'b0, 32'h40, 32'h0, 4'h0, rd, e, lat);
    total++; if (lat != 1 || rd !== 32'h12345678) begin
      bad++; $display("FAIL zw_load: lat=%0d data=%h exp lat=1 data=12345678", lat, rd);
    end
    @(posedge clk_in); #1;
    total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL zw_ready_again: got=%b exp=1", m_ready); end
    access(1'b0, 32'h41, 32'h0, 4'h0, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL zw_misaligned: err=%b data=%h exp err=1 data=0", e, rd);
    end
    access(1'b1, 32'h40, 32'h87654321, 4'hF, rd, e, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL zw_abort_latency: got=%0d exp=1", lat); end
    rst_b = 1'b0;
    @(posedge clk_in); #1;
    rst_b = 1'b1;
    access(1'b0, 32'h40, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL zw_abort_mem: got=%h exp=12345678", rd); end
    dut_sel = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    dut_sel = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2048, meaning the number of 32-bit words stored, indexed by addr[12:2].
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, meaning the wait cycles inserted between acceptance and response.
REQ-003 The block SHALL have port clk_in, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit, request valid from the CPU.
REQ-006 The block SHALL have port we, input, 1 bit: 1 means store, 0 means load.
REQ-007 The block SHALL have port addr, input, 32 bits, byte address.
REQ-008 The block SHALL have port wdata, input, 32 bits, store data.
REQ-009 The block SHALL have port be, input, 4 bits, store byte enables; be[i] selects wdata[8i+7:8i].
REQ-010 The block SHALL have port ready, output, 1 bit: the block can accept a request this cycle.
REQ-011 The block SHALL have port rvalid, output, 1 bit, a one-cycle response strobe.
REQ-012 The block SHALL have port rdata, output, 32 bits, load data, valid only while rvalid=1.
REQ-013 The block SHALL have port err, output, 1 bit, misaligned-access flag, valid only while rvalid=1.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP; ready=1 only in IDLE; rvalid=1 only in RESP.
REQ-015 Acceptance SHALL occur on the edge where req=1 and ready=1; addr, we, wdata and be are captured then, and later input changes are ignored.
REQ-016 On acceptance, the FSM SHALL go to WAIT with counter=WAIT_CYCLES, or straight to RESP when WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 1.
REQ-018 Latency SHALL be fixed: if accepted in cycle N, rvalid is high in cycle N+1+WAIT_CYCLES, and ready is high again in cycle N+2+WAIT_CYCLES.
REQ-019 RESP SHALL last exactly one cycle and then go unconditionally to IDLE; no back-to-back acceptance is possible.
REQ-020 A load SHALL drive rdata = word[addr[12:2]] as it was at acceptance, with err=0.
REQ-021 A store SHALL update only the lanes enabled by be, on the edge that ends RESP; rdata=0 during the store response.
REQ-022 A store with be=4'b0000 SHALL leave memory unchanged and still produce the normal response.
REQ-023 If addr[1:0]!=0, the response SHALL have err=1 and rdata=0, with no memory write, at the same latency.
REQ-024 addr[31:13] SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-025 Outside RESP, rdata and err SHALL be 0.
REQ-026 req while ready=0 SHALL be ignored, with no queuing.

Reset
REQ-027 While reset=0 at an edge, the block SHALL set state=IDLE, counter=0, ready=1 (the cycle after reset releases), rvalid=0, rdata=0 and err=0.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the access: no memory write commits and no rvalid is produced.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package dmem_pkg SHALL hold the state encoding, DEPTH, WAIT_CYCLES_MAX=15 and the addr index slice bounds (12, 2).
REQ-031 Storage SHALL be a sub-module dmem_array: one read port (async), one write port with byte enables, and no reset.
REQ-032 dmem_responder SHALL own the FSM, the counter, the request capture registers and the output registers.

Verification
REQ-033 With WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, be=F in cycle 0 -> rvalid in cycle 3, ready in cycle 4; a following load of 0x10 returns 0xDEADBEEF, err=0.
REQ-034 Store 0x11223344 to 0x20 with be=F, then store 0xAABBCCDD with be=0101 -> a load of 0x20 returns 0x11BB33DD.
REQ-035 Load from addr=0x22 -> err=1, rdata=0; a store to 0x22 leaves word 0x20 unchanged.
REQ-036 Store 0x5 to 0x2004 -> a load of 0x4 returns 0x5 (wrap-around check).
REQ-037 Hold req=1 continuously -> exactly one acceptance every WAIT_CYCLES+2 cycles; changes to addr during WAIT have no effect.
REQ-038 Store accepted, then reset=0 in WAIT -> no rvalid, ready=1 after release, and memory unchanged; repeat with WAIT_CYCLES=0 and check rvalid occurs 1 cycle after acceptance.
